// File: rtl/ahb_arbiter_rr_if.sv
// ahb_arbiter_rr_if
// Bundles the AHB arbitration signals seen by the round-robin arbiter.
//   HBUSREQ  per-master bus request
//   HTRANS   muxed transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HBURST   muxed burst type
//   HREADY   bus ready from the slave mux
//   HGRANT   one-hot grant (arbiter output)
//   HMASTER  address-phase owner index (arbiter output)
//   HMASTERD data-phase owner index (arbiter output)
//   dbg_rem  remaining-beat counter of the current fixed burst (debug)
//   dbg_last round-robin pointer, last winner (debug)
// Handshake: an edge with HREADY=1 accepts the address phase on the bus;
// HREADY=0 stalls everything that depends on it.
interface ahb_arbiter_rr_if #(
  parameter int NUM_MASTER = 2
);
  logic [NUM_MASTER-1:0] HBUSREQ;
  logic [1:0]            HTRANS;
  logic [2:0]            HBURST;
  logic                  HREADY;
  logic [NUM_MASTER-1:0] HGRANT;
  logic [2:0]            HMASTER;
  logic [2:0]            HMASTERD;
  logic [4:0]            dbg_rem;
  logic [2:0]            dbg_last;

  // Bus side: drives requests and the muxed address-phase controls.
  modport master (
    output HBUSREQ, HTRANS, HBURST, HREADY,
    input  HGRANT, HMASTER, HMASTERD, dbg_rem, dbg_last
  );

  // Arbiter side.
  modport slave (
    input  HBUSREQ, HTRANS, HBURST, HREADY,
    output HGRANT, HMASTER, HMASTERD, dbg_rem, dbg_last
  );
endinterface

// File: rtl/ahb_arbiter_rr.sv
// ahb_arbiter_rr
// AHB bus arbiter with rotating (or fixed) priority. Fixed-length bursts
// are never broken, and the grant moves while the second-to-last burst
// address is accepted so the next owner can drive NONSEQ with no gap.
// Ports:
//   HCLK    bus clock, all state changes on the rising edge
//   HRESET  synchronous active-high reset
//   bus     ahb_arbiter_rr_if.slave (requests, HTRANS/HBURST/HREADY in;
//           HGRANT/HMASTER/HMASTERD and debug state out)
module ahb_arbiter_rr #(
  parameter int NUM_MASTER     = 2,
  parameter int DEFAULT_MASTER = 0,
  parameter int ROUND_ROBIN    = 1
) (
  input logic            HCLK,
  input logic            HRESET,
  ahb_arbiter_rr_if.slave bus
);

  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [2:0] DFLT      = 3'(DEFAULT_MASTER);
  localparam logic [NUM_MASTER-1:0] DFLT_OH = NUM_MASTER'(1) << DEFAULT_MASTER;

  logic [NUM_MASTER-1:0] grant_q;
  logic [2:0]            hmaster_q;
  logic [2:0]            hmasterd_q;
  logic [4:0]            rem_q;
  logic [2:0]            last_q;

  logic [4:0] rem_next;
  logic [4:0] burst_len_m1;
  logic       arb_ok;
  logic [2:0] winner;
  logic       found;
  logic [3:0] cand;
  logic [2:0] grant_idx;

  // Beats left after a NONSEQ of a fixed burst; SINGLE/INCR are unbounded
  // from the arbiter's point of view and never protect the grant.
  always_comb begin
    burst_len_m1 = 5'd0;
    case (bus.HBURST)
      3'd2, 3'd3: burst_len_m1 = 5'd3;
      3'd4, 3'd5: burst_len_m1 = 5'd7;
      3'd6, 3'd7: burst_len_m1 = 5'd15;
      default:    burst_len_m1 = 5'd0;
    endcase
  end

  always_comb begin
    rem_next = rem_q;
    if (bus.HREADY) begin
      if (bus.HTRANS == TR_NONSEQ) begin
        rem_next = burst_len_m1;
      end else if (bus.HTRANS == TR_SEQ && rem_q != 5'd0) begin
        rem_next = rem_q - 5'd1;
      end
    end
  end

  // Arbitrate once at most one beat remains after this edge: the last
  // address is then the next one on the bus and the new owner follows it.
  assign arb_ok = bus.HREADY && (rem_next <= 5'd1);

  // Winner selection. Rotating: scan last+1, last+2, ... with last itself
  // scanned last. Fixed: lowest requesting index.
  always_comb begin
    winner = DFLT;
    found  = 1'b0;
    cand   = 4'd0;
    if (ROUND_ROBIN != 0) begin
      for (int i = 1; i <= NUM_MASTER; i++) begin
        cand = {1'b0, last_q} + 4'(i);
        if (cand >= 4'(NUM_MASTER)) cand = cand - 4'(NUM_MASTER);
        for (int j = 0; j < NUM_MASTER; j++) begin
          if (!found && cand == 4'(j) && bus.HBUSREQ[j]) begin
            found  = 1'b1;
            winner = 3'(j);
          end
        end
      end
    end else begin
      for (int j = NUM_MASTER - 1; j >= 0; j--) begin
        if (bus.HBUSREQ[j]) begin
          found  = 1'b1;
          winner = 3'(j);
        end
      end
    end
  end

  always_comb begin
    grant_idx = 3'd0;
    for (int j = 0; j < NUM_MASTER; j++) begin
      if (grant_q[j]) grant_idx = 3'(j);
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant_q    <= DFLT_OH;
      hmaster_q  <= DFLT;
      hmasterd_q <= DFLT;
      rem_q      <= 5'd0;
      last_q     <= DFLT;
    end else begin
      rem_q <= rem_next;
      if (bus.HREADY) begin
        hmaster_q  <= grant_idx;
        hmasterd_q <= hmaster_q;
      end
      if (arb_ok) begin
        if (found) begin
          grant_q <= NUM_MASTER'(1) << winner;
          last_q  <= winner;
        end else begin
          grant_q <= DFLT_OH;
        end
      end
    end
  end

  assign bus.HGRANT   = grant_q;
  assign bus.HMASTER  = hmaster_q;
  assign bus.HMASTERD = hmasterd_q;
  assign bus.dbg_rem  = rem_q;
  assign bus.dbg_last = last_q;

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// tb_ahb_arbiter_rr
// Drives two arbiters with identical stimulus: one rotating-priority with
// default master 0, one fixed-priority with default master 1. A reference
// model predicts grant/owner/beat state after every edge; a monitor on the
// falling edge compares the DUT outputs against the predicted queue.
module tb_ahb_arbiter_rr;
  localparam int NM = 3;
  localparam int W  = 34;

  logic clk;
  logic rst;

  ahb_arbiter_rr_if #(.NUM_MASTER(NM)) if0 ();
  ahb_arbiter_rr_if #(.NUM_MASTER(NM)) if1 ();

  ahb_arbiter_rr #(.NUM_MASTER(NM), .DEFAULT_MASTER(0), .ROUND_ROBIN(1)) dut0 (
    .HCLK(clk), .HRESET(rst), .bus(if0.slave)
  );
  ahb_arbiter_rr #(.NUM_MASTER(NM), .DEFAULT_MASTER(1), .ROUND_ROBIN(0)) dut1 (
    .HCLK(clk), .HRESET(rst), .bus(if1.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state, one slot per DUT.
  int m_grant[2];
  int m_hm[2];
  int m_hmd[2];
  int m_rem[2];
  int m_last[2];
  int m_dflt[2] = '{0, 1};
  int m_rr[2]   = '{1, 0};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Advance the model by one clock edge given the inputs seen at that edge.
  task automatic model_step(input logic r, input logic [NM-1:0] req,
                            input logic [1:0] tr, input logic [2:0] bu,
                            input logic rd);
    int len, rn, old_grant;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_grant[k] = m_dflt[k];
        m_hm[k]    = m_dflt[k];
        m_hmd[k]   = m_dflt[k];
        m_rem[k]   = 0;
        m_last[k]  = m_dflt[k];
      end else begin
        case (bu)
          3'd2, 3'd3: len = 4;
          3'd4, 3'd5: len = 8;
          3'd6, 3'd7: len = 16;
          default:    len = 1;
        endcase
        rn = m_rem[k];
        if (rd && tr == 2'd2) rn = len - 1;
        else if (rd && tr == 2'd3 && m_rem[k] > 0) rn = m_rem[k] - 1;
        ok = rd && (rn <= 1);
        old_grant = m_grant[k];
        if (rd) begin
          m_hmd[k] = m_hm[k];
          m_hm[k]  = old_grant;
        end
        if (ok) begin
          if (req == '0) begin
            m_grant[k] = m_dflt[k];
          end else if (m_rr[k] != 0) begin
            for (int i = 1; i <= NM; i++) begin
              if (req[(m_last[k] + i) % NM]) begin
                m_grant[k] = (m_last[k] + i) % NM;
                break;
              end
            end
            m_last[k] = m_grant[k];
          end else begin
            for (int i = 0; i < NM; i++) begin
              if (req[i]) begin
                m_grant[k] = i;
                break;
              end
            end
          end
        end
        m_rem[k] = rn;
      end
    end
  endtask

  function automatic logic [16:0] pack(input int k);
    logic [2:0] oh;
    oh = 3'(1 << m_grant[k]);
    return {oh, 3'(m_hm[k]), 3'(m_hmd[k]), 5'(m_rem[k]), 3'(m_last[k])};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("grant0",    8'(if0.HGRANT),   8'(e[33:31]));
      chk("hmaster0",  8'(if0.HMASTER),  8'(e[30:28]));
      chk("hmasterd0", 8'(if0.HMASTERD), 8'(e[27:25]));
      chk("rem0",      8'(if0.dbg_rem),  8'(e[24:20]));
      chk("last0",     8'(if0.dbg_last), 8'(e[19:17]));
      chk("grant1",    8'(if1.HGRANT),   8'(e[16:14]));
      chk("hmaster1",  8'(if1.HMASTER),  8'(e[13:11]));
      chk("hmasterd1", 8'(if1.HMASTERD), 8'(e[10:8]));
      chk("rem1",      8'(if1.dbg_rem),  8'(e[7:3]));
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic [NM-1:0] req,
                      input logic [1:0] tr, input logic [2:0] bu,
                      input logic rd);
    rst = r;
    if0.HBUSREQ = req; if1.HBUSREQ = req;
    if0.HTRANS  = tr;  if1.HTRANS  = tr;
    if0.HBURST  = bu;  if1.HBURST  = bu;
    if0.HREADY  = rd;  if1.HREADY  = rd;
    @(posedge clk);
    model_step(r, req, tr, bu, rd);
    exp_q.push_back({pack(0), pack(1)});
    #1;
  endtask

  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NSEQ = 2'd2, SEQ = 2'd3;

  initial begin
    int beats;
    logic [1:0] tr;
    logic [2:0] bu;
    logic rd, r;
    logic [NM-1:0] req;

    // Reset with everyone requesting, then release with master 1 asking.
    step(1, 3'b111, IDLE, 3'd0, 1);
    step(1, 3'b111, IDLE, 3'd0, 1);
    repeat (3) step(0, 3'b010, IDLE, 3'd0, 1);

    // Burst protection: master 0 owns and runs INCR4 while master 1 asks.
    repeat (3) step(0, 3'b001, IDLE, 3'd0, 1);
    step(0, 3'b011, NSEQ, 3'd3, 1);
    repeat (3) step(0, 3'b011, SEQ, 3'd3, 1);
    repeat (2) step(0, 3'b011, IDLE, 3'd0, 1);

    // Same burst with three wait states on the second SEQ.
    repeat (3) step(0, 3'b001, IDLE, 3'd0, 1);
    step(0, 3'b011, NSEQ, 3'd3, 1);
    step(0, 3'b011, SEQ, 3'd3, 1);
    repeat (3) step(0, 3'b011, SEQ, 3'd3, 0);
    repeat (2) step(0, 3'b011, SEQ, 3'd3, 1);
    repeat (2) step(0, 3'b011, IDLE, 3'd0, 1);

    // BUSY in the middle of a fixed burst must not release the grant.
    step(0, 3'b110, NSEQ, 3'd5, 1);
    step(0, 3'b110, SEQ, 3'd5, 1);
    repeat (2) step(0, 3'b110, BUSY, 3'd5, 1);
    repeat (6) step(0, 3'b110, SEQ, 3'd5, 1);

    // Rotation with everybody requesting SINGLE transfers.
    repeat (6) step(0, 3'b111, NSEQ, 3'd0, 1);

    // Nobody requesting falls back to the default master.
    repeat (3) step(0, 3'b000, IDLE, 3'd0, 1);

    // Reset in the middle of master 1's INCR8.
    repeat (2) step(0, 3'b010, IDLE, 3'd0, 1);
    step(0, 3'b010, NSEQ, 3'd5, 1);
    step(0, 3'b010, SEQ, 3'd5, 1);
    step(1, 3'b010, SEQ, 3'd5, 1);
    repeat (2) step(0, 3'b000, IDLE, 3'd0, 1);

    // Randomized traffic with protocol-shaped bursts, stalls and resets.
    beats = 0; tr = IDLE; bu = 3'd0; rd = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if (rd) begin
        if (beats == 0) begin
          if ($urandom_range(0, 2) != 0) begin
            tr = NSEQ;
            bu = 3'($urandom_range(0, 7));
          end else begin
            tr = IDLE;
          end
        end else begin
          tr = ($urandom_range(0, 4) == 0) ? BUSY : SEQ;
        end
      end
      rd  = ($urandom_range(0, 3) != 0);
      req = NM'($urandom_range(0, 7));
      r   = ($urandom_range(0, 149) == 0);
      step(r, req, tr, bu, rd);
      if (r) begin
        beats = 0;
        rd    = 1'b1;
      end else if (rd) begin
        if (tr == NSEQ) begin
          case (bu)
            3'd2, 3'd3: beats = 3;
            3'd4, 3'd5: beats = 7;
            3'd6, 3'd7: beats = 15;
            3'd1:       beats = $urandom_range(0, 3);
            default:    beats = 0;
          endcase
        end else if (tr == SEQ && beats > 0) begin
          beats--;
        end
      end
    end

    step(0, 3'b000, IDLE, 3'd0, 1);
    @(negedge clk);
    #1;
    chk("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/ahb_arbiter_rr.md
Name: ahb_arbiter_rr

Overview:
AHB bus arbiter that sits directly downstream of the DMA master's HBUSREQ/HGRANT pair. It arbitrates among the DMA master, a CPU master and other bus masters, and drives HGRANT, the address-phase owner index HMASTER, and the data-phase owner index HMASTERD. The address, control and data multiplexers use HMASTER and HMASTERD. Fixed-length bursts are never broken, and handover is zero-gap.

Parameters:
NUM_MASTER, 2, number of masters (2..8).
DEFAULT_MASTER, 0, master granted when nobody requests and after reset.
ROUND_ROBIN, 1, 1 = rotating priority; 0 = fixed priority, lowest index wins.

Ports:
HCLK  in  1  bus clock; all state changes on the rising edge.
HRESET  in  1  reset, synchronous, active-high.
HBUSREQ  in  NUM_MASTER  per-master bus request.
HTRANS  in  2  muxed bus HTRANS (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
HBURST  in  3  muxed bus HBURST (SINGLE=0, INCR=1, WRAP4/INCR4=2/3, WRAP8/INCR8=4/5, WRAP16/INCR16=6/7).
HREADY  in  1  bus HREADY from the slave mux.
HGRANT  out  NUM_MASTER  one-hot grant, registered.
HMASTER  out  3  address-phase owner index, registered.
HMASTERD  out  3  data-phase owner index, registered.

Behaviour:
- Reset values (HRESET=1 at an edge, overrides everything, including mid-burst):
  - HGRANT = one-hot(DEFAULT_MASTER).
  - HMASTER = HMASTERD = DEFAULT_MASTER.
  - Beat counter REM = 0.
  - Round-robin pointer LAST = DEFAULT_MASTER.
- Accept: an edge with HREADY=1 accepts the address phase currently on the bus.
- Beat counter REM (5 bits, remaining beats of the current fixed burst):
  - On accept with NONSEQ: REM = L-1, where L = 4/8/16 for HBURST 2-3/4-5/6-7, else 0.
  - On accept with SEQ and REM>0: REM = REM-1.
  - IDLE and BUSY leave REM unchanged.
  - HREADY=0 holds REM.
- REM_NEXT is the value REM takes at this edge.
- ARB_OK = HREADY=1 and REM_NEXT<=1.
  - Grant moves when the second-to-last burst address is accepted, so the new owner drives NONSEQ immediately after the last address with no gap.
  - SINGLE, INCR, IDLE: ARB_OK on every HREADY edge.
  - BUSY mid-burst with REM>1: not ARB_OK.
- Grant update (only at ARB_OK edges; otherwise HGRANT holds):
  - If no requests: HGRANT = one-hot(DEFAULT_MASTER).
  - ROUND_ROBIN=1: pick the first requesting index scanning LAST+1, LAST+2, ... wrapping modulo NUM_MASTER, with LAST itself scanned last. LAST = winner whenever a request existed.
  - ROUND_ROBIN=0: lowest requesting index.
- Ownership:
  - Every edge with HREADY=1: HMASTER = index(HGRANT) as it was before the edge, and HMASTERD = HMASTER as it was before the edge.
  - HREADY=0: both hold.
  - Latency: request to HGRANT is 1 edge when ARB_OK; HGRANT to HMASTER is 1 further HREADY edge; HMASTERD follows HMASTER by 1 HREADY edge.
- Simultaneous request and release in one cycle: the new request is considered at the same edge.
- Requests are sampled only at ARB_OK edges.
- A master that drops HBUSREQ mid fixed-burst keeps the grant until the burst ends.
- HGRANT is always exactly one-hot.

Test Plan:
- Reset check: NUM_MASTER=2. Drive HRESET=1 for 2 edges with HBUSREQ=2'b11 → HGRANT=2'b01, HMASTER=0, HMASTERD=0. Release reset with HBUSREQ=2'b10, HTRANS=IDLE, HREADY=1 → HGRANT=2'b10 after edge 1, HMASTER=1 after edge 2, HMASTERD=1 after edge 3.
- Burst protection: master0 owns, issues INCR4 (NONSEQ, SEQ, SEQ, SEQ, HREADY=1); master1 requests from the NONSEQ cycle → HGRANT stays 2'b01 through the first SEQ accept and becomes 2'b10 at the edge accepting the 2nd SEQ. HMASTER=1 at the edge accepting the 3rd SEQ, which is the last beat.
- Wait states: same INCR4, with HREADY=0 for 3 cycles on the 2nd SEQ → REM, HGRANT and HMASTER hold during the stall. The grant switch is delayed exactly 3 cycles.
- Rotation: ROUND_ROBIN=1, NUM_MASTER=3, all HBUSREQ=1, SINGLE transfers, HREADY=1 → grant sequence 1, 2, 0, 1 on successive edges. With ROUND_ROBIN=0 the same stimulus gives 0 constantly.
- Default master: all HBUSREQ=0 with DEFAULT_MASTER=1 → HGRANT=one-hot(1) after the next HREADY edge.
- Reset mid-burst: assert HRESET on the 2nd beat of master1's INCR8 → next edge HGRANT=one-hot(DEFAULT_MASTER), REM=0, HMASTER=HMASTERD=DEFAULT_MASTER.
